// File: rtl/serial_add_sub_unit.sv
// Bit-serial add/subtract unit: one full-adder cell walks the operands LSB
// first, one bit per clock, with the carry held in a register between bits.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request; start_ready high
// SHIFT | one operand bit per clock through the adder cell
// DONE  | result/flags presented with res_valid until res_ready
module serial_add_sub_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             c;
    logic [CNT_W-1:0] cnt;

    logic             cell_s;
    logic             cell_cout;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] r_sr_nxt;

    // The single full-adder cell and the bit-position decode feeding it.
    assign cell_s    = a_sr[0] ^ b_sr[0] ^ c;
    assign cell_cout = (a_sr[0] & b_sr[0]) | (c & (a_sr[0] ^ b_sr[0]));
    assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
    assign accept    = start_valid && (state == IDLE);
    assign r_sr_nxt  = {cell_s, r_sr[WIDTH-1:1]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        state_nxt   = state;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid) state_nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand/result shifters, carry and bit counter; outputs load on the
    // last bit only, so they stay put through SHIFT and after the handshake.
    // The carry still in c on the last bit is the carry into the MSB, so
    // overflow is taken straight from c ^ cell_cout on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
        end else if (accept) begin
            a_sr <= a_in;
            b_sr <= op_sub ? ~b_in : b_in;
            c    <= op_sub ? 1'b1 : cin;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sr <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr <= {1'b0, b_sr[WIDTH-1:1]};
            r_sr <= r_sr_nxt;
            c    <= cell_cout;
            cnt  <= cnt + 1'b1;
            if (last_bit) begin
                result <= r_sr_nxt;
                cout   <= cell_cout;
                ovf    <= c ^ cell_cout;
                zero   <= (r_sr_nxt == '0);
            end
        end
    end

endmodule

// File: tb/tb_serial_add_sub_unit.sv
// Directed bench for serial_add_sub_unit (WIDTH=8): arithmetic vectors,
// latency, backpressure and mid-operation reset.
module tb_serial_add_sub_unit;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start_valid;
    logic             start_ready;
    logic             op_sub;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             res_valid;
    logic             res_ready;
    logic             busy;

    int vectors    = 0;
    int miscompares = 0;
    logic [WIDTH-1:0] prev_result;

    serial_add_sub_unit #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_sub      (op_sub),
        .a_in        (a_in),
        .b_in        (b_in),
        .cin         (cin),
        .result      (result),
        .cout        (cout),
        .ovf         (ovf),
        .zero        (zero),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .busy        (busy)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and follow it through to the result handshake.
    task automatic run_op(input string tag, input logic sub, input logic [7:0] a,
                          input logic [7:0] b, input logic ci, input logic [7:0] exp_res,
                          input logic exp_cout, input logic exp_ovf, input logic exp_zero);
        check({tag, " start_ready"}, start_ready, 1);
        start_valid = 1'b1;
        op_sub      = sub;
        a_in        = a;
        b_in        = b;
        cin         = ci;
        tick();
        start_valid = 1'b0;
        a_in        = 8'hA5;
        b_in        = 8'h5A;
        op_sub      = ~sub;
        cin         = ~ci;
        for (int i = 1; i < WIDTH; i++) tick();
        check({tag, " res_valid early"}, res_valid, 0);
        check({tag, " busy"}, busy, 1);
        check({tag, " result held in shift"}, result, prev_result);
        tick();
        check({tag, " res_valid"}, res_valid, 1);
        check({tag, " result"}, result, exp_res);
        check({tag, " cout"}, cout, exp_cout);
        check({tag, " ovf"}, ovf, exp_ovf);
        check({tag, " zero"}, zero, exp_zero);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({tag, " res_valid drop"}, res_valid, 0);
        check({tag, " idle"}, start_ready, 1);
        check({tag, " result retained"}, result, exp_res);
        prev_result = exp_res;
    endtask

    initial begin
        rst_n       = 1'b0;
        start_valid = 1'b0;
        op_sub      = 1'b0;
        a_in        = '0;
        b_in        = '0;
        cin         = 1'b0;
        res_ready   = 1'b0;
        prev_result = '0;
        #12;
        check("reset result", result, 0);
        check("reset res_valid", res_valid, 0);
        check("reset start_ready", start_ready, 1);
        check("reset busy", busy, 0);
        check("reset flags", {cout, ovf, zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        run_op("add 3c+25", 1'b0, 8'h3C, 8'h25, 1'b0, 8'h61, 1'b0, 1'b0, 1'b0);
        run_op("add ff+01", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("add 7f+00+1", 1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("sub 80-01", 1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_op("sub 05-05 cin1", 1'b1, 8'h05, 8'h05, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("sub 00-01", 1'b1, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);

        // Backpressure: sit in DONE with res_ready low and poke a new request.
        start_valid = 1'b1;
        op_sub      = 1'b0;
        a_in        = 8'h3C;
        b_in        = 8'h25;
        cin         = 1'b0;
        tick();
        start_valid = 1'b0;
        for (int i = 1; i < WIDTH; i++) tick();
        tick();
        check("bp res_valid", res_valid, 1);
        for (int i = 0; i < 5; i++) begin
            start_valid = 1'b1;
            op_sub      = 1'b1;
            a_in        = 8'h11;
            b_in        = 8'h22;
            check("bp start_ready", start_ready, 0);
            tick();
            check("bp result", result, 8'h61);
            check("bp flags", {cout, ovf, zero}, 3'b000);
            check("bp res_valid held", res_valid, 1);
        end
        start_valid = 1'b0;
        res_ready   = 1'b1;
        tick();
        res_ready = 1'b0;
        check("bp release res_valid", res_valid, 0);
        check("bp release start_ready", start_ready, 1);
        prev_result = 8'h61;
        run_op("after bp 11-22", 1'b1, 8'h11, 8'h22, 1'b0, 8'hEF, 1'b0, 1'b0, 1'b0);

        // Reset after bit 3 of an operation.
        start_valid = 1'b1;
        op_sub      = 1'b0;
        a_in        = 8'h7F;
        b_in        = 8'h01;
        cin         = 1'b0;
        tick();
        start_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("pre-reset busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid reset result", result, 0);
        check("mid reset start_ready", start_ready, 1);
        check("mid reset busy", busy, 0);
        check("mid reset res_valid", res_valid, 0);
        check("mid reset flags", {cout, ovf, zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < WIDTH + 2; i++) begin
            tick();
            check("no res_valid after abort", res_valid, 0);
        end
        prev_result = 8'h00;
        run_op("add 10+20", 1'b0, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
